// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV32I execute stage: ALU/branch/write-back codes,
// the packed control bundle and the iterative-multiplier state encoding.
package rv_pipe_pkg;

  localparam int unsigned ALU_OP_W      = 4;
  localparam int unsigned WB_SRC_W      = 3;
  localparam int unsigned JB_W          = 4;
  localparam int unsigned CTRL_BUNDLE_W = ALU_OP_W + 1 + WB_SRC_W + JB_W + 1 + 1;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [JB_W-1:0] {
    JB_NONE = 4'd0,
    JB_BEQ  = 4'd1,
    JB_BNE  = 4'd2,
    JB_BLT  = 4'd3,
    JB_BGE  = 4'd4,
    JB_BLTU = 4'd5,
    JB_BGEU = 4'd6,
    JB_JAL  = 4'd7,
    JB_JALR = 4'd8
  } jb_e;

  typedef enum logic [WB_SRC_W-1:0] {
    WB_ALU  = 3'b000,
    WB_LOAD = 3'b001,
    WB_PC4  = 3'b010,
    WB_IMM  = 3'b011,
    WB_JUMP = 3'b100
  } wb_src_e;

  // Bit layout, MSB first: {alu_op[3:0], op_src_imm, wb_src[2:0], jb[3:0], mem_we, is_mul}
  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                op_src_imm;
    logic [WB_SRC_W-1:0] wb_src;
    logic [JB_W-1:0]     jb;
    logic                mem_we;
    logic                is_mul;
  } ctrl_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/rv_pipe_exec_stage_if.sv
// Decode-side and memory-side handshake/bus of the execute stage.
// slave: the execute stage view; master: the surrounding pipeline view.
interface rv_pipe_exec_stage_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CTRL_W     = rv_pipe_pkg::CTRL_BUNDLE_W
);
  // decode -> execute
  logic                  i_valid;
  logic                  o_ready;
  logic [CTRL_W-1:0]     i_ctrl;
  logic [WIDTH-1:0]      i_pc;
  logic [WIDTH-1:0]      i_imm;
  logic [REG_ADDR_W-1:0] i_rs1;
  logic [REG_ADDR_W-1:0] i_rs2;
  logic [REG_ADDR_W-1:0] i_rd;
  logic [WIDTH-1:0]      i_rs1_data;
  logic [WIDTH-1:0]      i_rs2_data;
  // execute -> memory
  logic                  o_valid;
  logic                  i_ready;
  logic [WIDTH-1:0]      o_result;
  logic [WIDTH-1:0]      o_store_data;
  logic [REG_ADDR_W-1:0] o_rd;
  logic [2:0]            o_wb_src;
  logic                  o_mem_we;
  logic                  o_illegal;

  modport slave (
    input  i_valid, i_ctrl, i_pc, i_imm, i_rs1, i_rs2, i_rd, i_rs1_data, i_rs2_data, i_ready,
    output o_ready, o_valid, o_result, o_store_data, o_rd, o_wb_src, o_mem_we, o_illegal
  );

  modport master (
    output i_valid, i_ctrl, i_pc, i_imm, i_rs1, i_rs2, i_rd, i_rs1_data, i_rs2_data, i_ready,
    input  o_ready, o_valid, o_result, o_store_data, o_rd, o_wb_src, o_mem_we, o_illegal
  );
endinterface

// File: rtl/rv_iter_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH
// bits of the product. IDLE -> BUSY (WIDTH cycles) -> DONE -> IDLE on ack.
module rv_iter_mul
  import rv_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_ack,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mul_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;

  // Multiplier sequencer and datapath; abort returns to IDLE immediately
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= MUL_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
    end else if (i_abort) begin
      r_state <= MUL_IDLE;
    end else begin
      case (r_state)
        MUL_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (r_b[0]) r_acc <= r_acc + r_a;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= MUL_DONE;
        end
        MUL_DONE: begin
          if (i_ack) r_state <= MUL_IDLE;
        end
        default: r_state <= MUL_IDLE;
      endcase
    end
  end

  assign o_busy    = (r_state == MUL_BUSY);
  assign o_done    = (r_state == MUL_DONE);
  assign o_product = r_acc;

endmodule

// File: rtl/rv_pipe_exec_stage.sv
// RV32I execute stage: ID/EX register, MEM/WB operand forwarding, ALU,
// branch resolution and redirect, EX/MEM register with valid/ready handshakes.
// Build option: define RV_EXEC_MUL_EN to execute is_mul ops on rv_iter_mul;
// otherwise is_mul ops retire in one cycle as illegal with no register write.
module rv_pipe_exec_stage
  import rv_pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CTRL_W     = CTRL_BUNDLE_W
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_flush,
  input  logic                  i_mem_fwd_en,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic [WIDTH-1:0]      i_mem_data,
  input  logic                  i_wb_fwd_en,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [WIDTH-1:0]      i_wb_data,
  output logic                  o_redirect,
  output logic [WIDTH-1:0]      o_redirect_pc,
  rv_pipe_exec_stage_if.slave   io_bus
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  // ID/EX register
  logic                  r_ex_valid;
  ctrl_t                 r_ex_ctrl;
  logic [WIDTH-1:0]      r_ex_pc;
  logic [WIDTH-1:0]      r_ex_imm;
  logic [REG_ADDR_W-1:0] r_ex_rs1;
  logic [REG_ADDR_W-1:0] r_ex_rs2;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic [WIDTH-1:0]      r_ex_rs1_data;
  logic [WIDTH-1:0]      r_ex_rs2_data;

  // EX/MEM register
  logic                  r_mem_valid;
  logic [WIDTH-1:0]      r_mem_result;
  logic [WIDTH-1:0]      r_mem_store_data;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic [2:0]            r_mem_wb_src;
  logic                  r_mem_we;
  logic                  r_mem_illegal;

  ctrl_t                 w_in_ctrl;
  logic [WIDTH-1:0]      w_rs1_fwd;
  logic [WIDTH-1:0]      w_rs2_fwd;
  logic [WIDTH-1:0]      w_op_a;
  logic [WIDTH-1:0]      w_op_b;
  logic [SHAMT_W-1:0]    w_shamt;
  logic [WIDTH-1:0]      w_alu_res;
  logic                  w_alu_bad;
  logic                  w_taken;
  logic                  w_jb_bad;
  logic [WIDTH-1:0]      w_br_target;
  logic [WIDTH-1:0]      w_jalr_target;
  logic [WIDTH-1:0]      w_target;
  logic [WIDTH-1:0]      w_result;
  logic                  w_illegal;
  logic [REG_ADDR_W-1:0] w_rd;
  logic                  w_mem_we;
  logic                  w_mul_wait;
  logic                  w_advance;
  logic                  w_redirect;
  logic                  w_ready;
  logic                  w_accept;

  assign w_in_ctrl = ctrl_t'(io_bus.i_ctrl);

  // Operand forwarding: MEM beats WB beats register file, x0 never forwarded
  always_comb begin
    w_rs1_fwd = r_ex_rs1_data;
    if (i_mem_fwd_en && (i_mem_rd == r_ex_rs1) && (r_ex_rs1 != '0))
      w_rs1_fwd = i_mem_data;
    else if (i_wb_fwd_en && (i_wb_rd == r_ex_rs1) && (r_ex_rs1 != '0))
      w_rs1_fwd = i_wb_data;

    w_rs2_fwd = r_ex_rs2_data;
    if (i_mem_fwd_en && (i_mem_rd == r_ex_rs2) && (r_ex_rs2 != '0))
      w_rs2_fwd = i_mem_data;
    else if (i_wb_fwd_en && (i_wb_rd == r_ex_rs2) && (r_ex_rs2 != '0))
      w_rs2_fwd = i_wb_data;
  end

  assign w_op_a  = w_rs1_fwd;
  assign w_op_b  = r_ex_ctrl.op_src_imm ? r_ex_imm : w_rs2_fwd;
  assign w_shamt = w_op_b[SHAMT_W-1:0];

  // ALU; unknown op codes produce 0 and flag illegal
  always_comb begin
    w_alu_res = '0;
    w_alu_bad = 1'b0;
    case (r_ex_ctrl.alu_op)
      ALU_ADD:  w_alu_res = w_op_a + w_op_b;
      ALU_SUB:  w_alu_res = w_op_a - w_op_b;
      ALU_AND:  w_alu_res = w_op_a & w_op_b;
      ALU_OR:   w_alu_res = w_op_a | w_op_b;
      ALU_XOR:  w_alu_res = w_op_a ^ w_op_b;
      ALU_SLL:  w_alu_res = w_op_a << w_shamt;
      ALU_SRL:  w_alu_res = w_op_a >> w_shamt;
      ALU_SRA:  w_alu_res = $unsigned($signed(w_op_a) >>> w_shamt);
      ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (w_op_a < w_op_b)};
      default:  w_alu_bad = 1'b1;
    endcase
  end

  // Branch/jump resolution on forwarded register operands
  always_comb begin
    w_taken  = 1'b0;
    w_jb_bad = 1'b0;
    case (r_ex_ctrl.jb)
      JB_NONE: w_taken = 1'b0;
      JB_BEQ:  w_taken = (w_rs1_fwd == w_rs2_fwd);
      JB_BNE:  w_taken = (w_rs1_fwd != w_rs2_fwd);
      JB_BLT:  w_taken = ($signed(w_rs1_fwd) <  $signed(w_rs2_fwd));
      JB_BGE:  w_taken = ($signed(w_rs1_fwd) >= $signed(w_rs2_fwd));
      JB_BLTU: w_taken = (w_rs1_fwd <  w_rs2_fwd);
      JB_BGEU: w_taken = (w_rs1_fwd >= w_rs2_fwd);
      JB_JAL:  w_taken = 1'b1;
      JB_JALR: w_taken = 1'b1;
      default: w_jb_bad = 1'b1;
    endcase
  end

  assign w_br_target   = r_ex_pc + r_ex_imm;
  assign w_jalr_target = (w_rs1_fwd + r_ex_imm) & ~WIDTH'(1);
  assign w_target      = (r_ex_ctrl.jb == JB_JALR) ? w_jalr_target : w_br_target;

`ifdef RV_EXEC_MUL_EN
  logic             w_mul_start;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;

  assign w_mul_start = r_ex_valid & r_ex_ctrl.is_mul & ~w_mul_busy & ~w_mul_done & ~i_flush;
  assign w_mul_wait  = r_ex_valid & r_ex_ctrl.is_mul & ~w_mul_done;

  rv_iter_mul #(.WIDTH(WIDTH)) u_mul (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_start   (w_mul_start),
    .i_abort   (i_flush),
    .i_ack     (w_advance),
    .i_a       (w_rs1_fwd),
    .i_b       (w_rs2_fwd),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );
`else
  assign w_mul_wait = 1'b0;
`endif

  // Result select and write-back qualification
  always_comb begin
    w_illegal = w_alu_bad | w_jb_bad;
    w_rd      = r_ex_rd;
    w_mem_we  = r_ex_ctrl.mem_we;
    case (r_ex_ctrl.wb_src)
      WB_ALU, WB_LOAD: w_result = w_alu_res;
      WB_PC4:          w_result = r_ex_pc + WIDTH'(4);
      WB_IMM:          w_result = r_ex_imm;
      WB_JUMP:         w_result = w_target;
      default:         w_result = '0;
    endcase
    if (r_ex_ctrl.is_mul) begin
`ifdef RV_EXEC_MUL_EN
      w_result  = w_mul_product;
      w_illegal = 1'b0;
`else
      w_result  = '0;
      w_illegal = 1'b1;
      w_rd      = '0;
      w_mem_we  = 1'b0;
`endif
    end
  end

  // Handshake, advance and redirect control
  assign w_advance  = r_ex_valid & (~r_mem_valid | io_bus.i_ready) & ~w_mul_wait;
  assign w_redirect = w_advance & w_taken & ~i_flush;
  assign w_ready    = (~r_ex_valid | w_advance) & ~w_redirect;
  assign w_accept   = io_bus.i_valid & w_ready;

  // ID/EX register: flush beats accept
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ex_valid    <= 1'b0;
      r_ex_ctrl     <= ctrl_t'('0);
      r_ex_pc       <= '0;
      r_ex_imm      <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
    end else if (i_flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_accept) begin
      r_ex_valid    <= 1'b1;
      r_ex_ctrl     <= w_in_ctrl;
      r_ex_pc       <= io_bus.i_pc;
      r_ex_imm      <= io_bus.i_imm;
      r_ex_rs1      <= io_bus.i_rs1;
      r_ex_rs2      <= io_bus.i_rs2;
      r_ex_rd       <= io_bus.i_rd;
      r_ex_rs1_data <= io_bus.i_rs1_data;
      r_ex_rs2_data <= io_bus.i_rs2_data;
    end else if (w_advance) begin
      r_ex_valid <= 1'b0;
    end
  end

  // EX/MEM register: holds under downstream stall
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_mem_valid      <= 1'b0;
      r_mem_result     <= '0;
      r_mem_store_data <= '0;
      r_mem_rd         <= '0;
      r_mem_wb_src     <= '0;
      r_mem_we         <= 1'b0;
      r_mem_illegal    <= 1'b0;
    end else if (i_flush) begin
      r_mem_valid <= 1'b0;
    end else if (w_advance) begin
      r_mem_valid      <= 1'b1;
      r_mem_result     <= w_result;
      r_mem_store_data <= w_rs2_fwd;
      r_mem_rd         <= w_rd;
      r_mem_wb_src     <= r_ex_ctrl.wb_src;
      r_mem_we         <= w_mem_we;
      r_mem_illegal    <= w_illegal;
    end else if (io_bus.i_ready) begin
      r_mem_valid <= 1'b0;
    end
  end

  assign io_bus.o_ready      = w_ready;
  assign io_bus.o_valid      = r_mem_valid;
  assign io_bus.o_result     = r_mem_result;
  assign io_bus.o_store_data = r_mem_store_data;
  assign io_bus.o_rd         = r_mem_rd;
  assign io_bus.o_wb_src     = r_mem_wb_src;
  assign io_bus.o_mem_we     = r_mem_we;
  assign io_bus.o_illegal    = r_mem_valid & r_mem_illegal;
  assign o_redirect          = w_redirect;
  assign o_redirect_pc       = w_target;

endmodule

// File: tb/tb_rv_pipe_exec_stage.sv
// Directed bench for rv_pipe_exec_stage: a vector table of single-instruction
// cases plus hand sequences for forwarding, stall, flush and multiply.
module tb_rv_pipe_exec_stage;
  import rv_pipe_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned RW = 5;

  typedef struct {
    logic [13:0]   ctrl;
    logic [W-1:0]  pc;
    logic [W-1:0]  imm;
    logic [W-1:0]  d1;
    logic [W-1:0]  d2;
    logic [RW-1:0] rd;
    logic [W-1:0]  res;
    logic          redir;
    logic [W-1:0]  rpc;
    logic          ill;
    logic [RW-1:0] erd;
  } vec_t;

  logic          clk;
  logic          rstn;
  logic          flush;
  logic          mem_fwd_en;
  logic [RW-1:0] mem_rd;
  logic [W-1:0]  mem_data;
  logic          wb_fwd_en;
  logic [RW-1:0] wb_rd;
  logic [W-1:0]  wb_data;
  logic          redirect;
  logic [W-1:0]  redirect_pc;

  int n_vec  = 0;
  int n_miss = 0;

  rv_pipe_exec_stage_if #(.WIDTH(W), .REG_ADDR_W(RW), .CTRL_W(CTRL_BUNDLE_W)) bus ();

  rv_pipe_exec_stage #(.WIDTH(W), .REG_ADDR_W(RW), .CTRL_W(CTRL_BUNDLE_W)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_flush       (flush),
    .i_mem_fwd_en  (mem_fwd_en),
    .i_mem_rd      (mem_rd),
    .i_mem_data    (mem_data),
    .i_wb_fwd_en   (wb_fwd_en),
    .i_wb_rd       (wb_rd),
    .i_wb_data     (wb_data),
    .o_redirect    (redirect),
    .o_redirect_pc (redirect_pc),
    .io_bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [13:0] c, input logic [W-1:0] pc, input logic [W-1:0] imm,
                       input logic [RW-1:0] rs1, input logic [RW-1:0] rs2, input logic [RW-1:0] rd,
                       input logic [W-1:0] d1, input logic [W-1:0] d2);
    bus.i_ctrl     = c;
    bus.i_pc       = pc;
    bus.i_imm      = imm;
    bus.i_rs1      = rs1;
    bus.i_rs2      = rs2;
    bus.i_rd       = rd;
    bus.i_rs1_data = d1;
    bus.i_rs2_data = d2;
    bus.i_valid    = 1'b1;
  endtask

  function automatic logic [13:0] mk(input logic [3:0] alu, input logic si, input logic [2:0] wb,
                                     input logic [3:0] jb, input logic we, input logic mul);
    return {alu, si, wb, jb, we, mul};
  endfunction

  function automatic vec_t v(input logic [13:0] c, input logic [W-1:0] pc, input logic [W-1:0] imm,
                             input logic [W-1:0] d1, input logic [W-1:0] d2, input logic [RW-1:0] rd,
                             input logic [W-1:0] res, input logic redir, input logic [W-1:0] rpc,
                             input logic ill, input logic [RW-1:0] erd);
    vec_t t;
    t.ctrl = c; t.pc = pc; t.imm = imm; t.d1 = d1; t.d2 = d2; t.rd = rd;
    t.res = res; t.redir = redir; t.rpc = rpc; t.ill = ill; t.erd = erd;
    return t;
  endfunction

  vec_t tbl[$];
  vec_t t;
  int   cycles;

  initial begin
    // single-instruction vectors: ctrl, pc, imm, rs1 data, rs2 data, rd -> result, redirect, target, illegal, rd out
    tbl.push_back(v(mk(ALU_ADD, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 5, 7, 3, 12, 0, 0, 0, 3));
    tbl.push_back(v(mk(ALU_SUB, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 5, 7, 4, 32'hFFFF_FFFE, 0, 0, 0, 4));
    tbl.push_back(v(mk(ALU_AND, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 32'hF0F0, 32'hFF00, 5, 32'hF000, 0, 0, 0, 5));
    tbl.push_back(v(mk(ALU_OR,  0, WB_ALU, JB_NONE, 0, 0), 0, 0, 32'hF0F0, 32'h0F0F, 6, 32'hFFFF, 0, 0, 0, 6));
    tbl.push_back(v(mk(ALU_XOR, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 32'hFF00, 32'h0FF0, 7, 32'hF0F0, 0, 0, 0, 7));
    tbl.push_back(v(mk(ALU_SLL, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 1, 33, 8, 2, 0, 0, 0, 8));
    tbl.push_back(v(mk(ALU_SRL, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 32'h8000_0000, 4, 9, 32'h0800_0000, 0, 0, 0, 9));
    tbl.push_back(v(mk(ALU_SRA, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 32'h8000_0000, 4, 10, 32'hF800_0000, 0, 0, 0, 10));
    tbl.push_back(v(mk(ALU_SLT, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 32'hFFFF_FFFF, 1, 11, 1, 0, 0, 0, 11));
    tbl.push_back(v(mk(ALU_SLTU, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 32'hFFFF_FFFF, 1, 12, 0, 0, 0, 0, 12));
    tbl.push_back(v(mk(ALU_ADD, 1, WB_ALU, JB_NONE, 0, 0), 0, 32'hFFFF_FFFC, 100, 0, 13, 96, 0, 0, 0, 13));
    tbl.push_back(v(mk(ALU_ADD, 0, WB_ALU, JB_BEQ, 0, 0), 32'h100, 32'h20, 9, 9, 0, 18, 1, 32'h120, 0, 0));
    tbl.push_back(v(mk(ALU_ADD, 0, WB_ALU, JB_BNE, 0, 0), 32'h100, 32'h20, 9, 9, 0, 18, 0, 0, 0, 0));
    tbl.push_back(v(mk(ALU_SUB, 0, WB_ALU, JB_BLT, 0, 0), 32'h200, 32'h10, 32'hFFFF_FFFB, 3, 0, 32'hFFFF_FFF8, 1, 32'h210, 0, 0));
    tbl.push_back(v(mk(ALU_ADD, 0, WB_ALU, JB_BGE, 0, 0), 32'h200, 32'h10, 32'hFFFF_FFFB, 3, 0, 32'hFFFF_FFFE, 0, 0, 0, 0));
    tbl.push_back(v(mk(ALU_SUB, 0, WB_ALU, JB_BGEU, 0, 0), 32'h200, 32'h10, 3, 32'hFFFF_FFFB, 0, 8, 0, 0, 0, 0));
    tbl.push_back(v(mk(ALU_ADD, 1, WB_PC4, JB_JALR, 0, 0), 32'h40, 4, 32'h1003, 0, 1, 32'h44, 1, 32'h1006, 0, 1));
    tbl.push_back(v(mk(ALU_ADD, 0, WB_JUMP, JB_JAL, 0, 0), 32'h80, 32'h100, 0, 0, 2, 32'h180, 1, 32'h180, 0, 2));
    tbl.push_back(v(mk(ALU_ADD, 1, WB_IMM, JB_NONE, 0, 0), 0, 32'h1234_5000, 77, 0, 14, 32'h1234_5000, 0, 0, 0, 14));
    tbl.push_back(v(mk(ALU_ADD, 0, 3'b101, JB_NONE, 0, 0), 0, 0, 5, 7, 15, 0, 0, 0, 0, 15));
    tbl.push_back(v(mk(ALU_ADD, 1, WB_LOAD, JB_NONE, 1, 0), 0, 8, 32'h1000, 32'hDEAD_BEEF, 0, 32'h1008, 0, 0, 0, 0));
    tbl.push_back(v(mk(4'hF, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 5, 7, 16, 0, 0, 0, 1, 16));

    rstn = 1'b0; flush = 1'b0;
    mem_fwd_en = 1'b0; mem_rd = '0; mem_data = '0;
    wb_fwd_en = 1'b0; wb_rd = '0; wb_data = '0;
    bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_ctrl = '0; bus.i_pc = '0; bus.i_imm = '0;
    bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_rd = '0; bus.i_rs1_data = '0; bus.i_rs2_data = '0;

    // reset state
    #12;
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_result", bus.o_result, 0);
    chk("rst_rd", 32'(bus.o_rd), 0);
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_ready", 32'(bus.o_ready), 1);
    rstn = 1'b1;
    tick();

    // vector table
    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      issue(t.ctrl, t.pc, t.imm, 5'd1, 5'd2, t.rd, t.d1, t.d2);
      tick();
      bus.i_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_redirect", i), 32'(redirect), 32'(t.redir));
      if (t.redir) chk($sformatf("v%0d_redirect_pc", i), redirect_pc, t.rpc);
      chk($sformatf("v%0d_ready", i), 32'(bus.o_ready), 32'(!t.redir));
      tick();
      chk($sformatf("v%0d_valid", i), 32'(bus.o_valid), 1);
      chk($sformatf("v%0d_result", i), bus.o_result, t.res);
      chk($sformatf("v%0d_rd", i), 32'(bus.o_rd), 32'(t.erd));
      chk($sformatf("v%0d_illegal", i), 32'(bus.o_illegal), 32'(t.ill));
      chk($sformatf("v%0d_store", i), bus.o_store_data, t.d2);
      chk($sformatf("v%0d_wb_src", i), 32'(bus.o_wb_src), 32'(t.ctrl[8:6]));
      chk($sformatf("v%0d_mem_we", i), 32'(bus.o_mem_we), 32'(t.ctrl[1]));
      chk($sformatf("v%0d_redirect_after", i), 32'(redirect), 0);
      tick();
    end

    // forwarding: MEM beats WB on rs1, WB alone on rs2 -> 12 + 1000
    issue(mk(ALU_ADD, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 5'd3, 5'd4, 5'd6, 55, 1);
    mem_fwd_en = 1'b1; mem_rd = 5'd3; mem_data = 12;
    wb_fwd_en = 1'b1; wb_rd = 5'd4; wb_data = 1000;
    tick();
    bus.i_valid = 1'b0;
    tick();
    chk("fwd_mem_beats_wb", bus.o_result, 1012);
    chk("fwd_store_wb", bus.o_store_data, 1000);
    tick();
    // MEM and WB both match rs1 -> MEM value
    issue(mk(ALU_ADD, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 5'd3, 5'd9, 5'd6, 55, 0);
    wb_rd = 5'd3; wb_data = 99;
    tick();
    bus.i_valid = 1'b0;
    tick();
    chk("fwd_mem_over_wb_same_rd", bus.o_result, 12);
    tick();
    // x0 never forwarded
    issue(mk(ALU_ADD, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 5'd0, 5'd9, 5'd6, 7, 1);
    mem_rd = 5'd0; wb_rd = 5'd0;
    tick();
    bus.i_valid = 1'b0;
    tick();
    chk("fwd_x0_uses_rf", bus.o_result, 8);
    tick();
    mem_fwd_en = 1'b0; wb_fwd_en = 1'b0;

    // downstream stall for 3 cycles, then flush mid-stall
    bus.i_ready = 1'b0;
    issue(mk(ALU_ADD, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 5'd1, 5'd2, 5'd3, 5, 7);
    tick();
    issue(mk(ALU_ADD, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 5'd1, 5'd2, 5'd4, 1, 1);
    #1;
    chk("stall_second_accept_ready", 32'(bus.o_ready), 1);
    tick();
    bus.i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_valid", k), 32'(bus.o_valid), 1);
      chk($sformatf("stall%0d_result", k), bus.o_result, 12);
      chk($sformatf("stall%0d_rd", k), 32'(bus.o_rd), 3);
      chk($sformatf("stall%0d_ready", k), 32'(bus.o_ready), 0);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_clears_valid", 32'(bus.o_valid), 0);
    chk("flush_ready", 32'(bus.o_ready), 1);
    bus.i_ready = 1'b1;

    // flush together with handshake: instruction dropped
    issue(mk(ALU_ADD, 0, WB_ALU, JB_NONE, 0, 0), 0, 0, 5'd1, 5'd2, 5'd3, 5, 7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.i_valid = 1'b0;
    tick();
    chk("flush_drops_accept", 32'(bus.o_valid), 0);

    // flush suppresses a taken branch redirect
    issue(mk(ALU_ADD, 0, WB_ALU, JB_BEQ, 0, 0), 32'h100, 32'h20, 5'd1, 5'd2, 5'd0, 9, 9);
    tick();
    bus.i_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_kills_redirect", 32'(redirect), 0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_kills_branch", 32'(bus.o_valid), 0);

    // multiply 6 * 7
    issue(mk(ALU_ADD, 0, WB_ALU, JB_NONE, 0, 1), 0, 0, 5'd1, 5'd2, 5'd5, 6, 7);
    tick();
    bus.i_valid = 1'b0;
`ifdef RV_EXEC_MUL_EN
    #1;
    chk("mul_ready_low", 32'(bus.o_ready), 0);
    cycles = 0;
    while (!bus.o_valid && cycles < 200) begin
      tick();
      cycles++;
    end
    chk("mul_latency", 32'(cycles), W + 2);
    chk("mul_result", bus.o_result, 42);
    chk("mul_rd", 32'(bus.o_rd), 5);
    chk("mul_illegal", 32'(bus.o_illegal), 0);
`else
    cycles = 0;
    tick();
    chk("mul_valid", 32'(bus.o_valid), 1);
    chk("mul_illegal", 32'(bus.o_illegal), 1);
    chk("mul_result", bus.o_result, 0);
    chk("mul_rd", 32'(bus.o_rd), 0);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
